// File: rtl/k_fft_peak_finder.sv
// rtl/k_fft_peak_finder.sv - per-frame |re|+|im| peak search over an FFT output stream
// Reports the index and magnitude of the strongest bin once per frame and flags frame-length errors.
module k_fft_peak_finder #(
   parameter int TRANSFORM_LENGTH = 1024,
   parameter int DATA_W           = 16,
   parameter int SKIP_DC          = 1,
   localparam int BIN_W           = $clog2(TRANSFORM_LENGTH),
   localparam int MAG_W           = DATA_W/2 + 1
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [DATA_W-1:0] s_axis_data_tdata,
   input  logic              s_axis_data_tvalid,
   output logic              s_axis_data_tready,
   input  logic              s_axis_data_tlast,
   output logic [BIN_W-1:0]  m_peak_bin,
   output logic [MAG_W-1:0]  m_peak_mag,
   output logic              m_peak_err,
   output logic              m_peak_valid,
   input  logic              m_peak_ready,
   output logic              event_tlast_unexpected,
   output logic              event_tlast_missing
);
   localparam int HALF_W = DATA_W/2;
   localparam logic [BIN_W-1:0] LAST_BIN   = BIN_W'(TRANSFORM_LENGTH-1);
   localparam logic [BIN_W-1:0] FIRST_ELIG = BIN_W'((SKIP_DC != 0) ? 1 : 0);

   typedef enum logic {ACCUM, HOLD} state_t;
   state_t state_q, state_d;

   logic [BIN_W-1:0] bin_cnt, max_bin, upd_bin;
   logic [MAG_W-1:0] max_mag, upd_mag, mag;
   logic signed [HALF_W-1:0] re, im;
   logic [HALF_W-1:0] abs_re, abs_im;
   logic beat, at_last, frame_end, eligible, take, out_handshake;

   // -(-2^(HALF_W-1)) wraps back to the same bit pattern, which read unsigned is the correct magnitude
   assign re     = s_axis_data_tdata[HALF_W-1:0];
   assign im     = s_axis_data_tdata[DATA_W-1:HALF_W];
   assign abs_re = re[HALF_W-1] ? $unsigned(-re) : $unsigned(re);
   assign abs_im = im[HALF_W-1] ? $unsigned(-im) : $unsigned(im);
   assign mag    = {1'b0, abs_re} + {1'b0, abs_im};

   assign beat          = s_axis_data_tvalid && s_axis_data_tready;
   assign at_last       = (bin_cnt == LAST_BIN);
   assign frame_end     = beat && (s_axis_data_tlast || at_last);
   assign eligible      = (SKIP_DC == 0) || (bin_cnt != '0);
   // Strict '>' keeps the lowest index on ties
   assign take          = beat && eligible && ((bin_cnt == FIRST_ELIG) || (mag > max_mag));
   assign upd_bin       = take ? bin_cnt : max_bin;
   assign upd_mag       = take ? mag : max_mag;
   assign out_handshake = m_peak_valid && m_peak_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:   if (frame_end) state_d = HOLD;
         HOLD:    if (out_handshake) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q                <= ACCUM;
         s_axis_data_tready     <= 1'b0;
         m_peak_valid           <= 1'b0;
         bin_cnt                <= '0;
         max_bin                <= '0;
         max_mag                <= '0;
         m_peak_bin             <= '0;
         m_peak_mag             <= '0;
         m_peak_err             <= 1'b0;
         event_tlast_unexpected <= 1'b0;
         event_tlast_missing    <= 1'b0;
      end else begin
         state_q                <= state_d;
         s_axis_data_tready     <= (state_d == ACCUM);
         m_peak_valid           <= (state_d == HOLD);
         event_tlast_unexpected <= beat && s_axis_data_tlast && !at_last;
         event_tlast_missing    <= beat && at_last && !s_axis_data_tlast;
         if (beat) begin
            bin_cnt <= frame_end ? '0 : bin_cnt + 1'b1;
            max_bin <= upd_bin;
            max_mag <= upd_mag;
         end
         if (frame_end) begin
            m_peak_bin <= upd_bin;
            m_peak_mag <= upd_mag;
            m_peak_err <= (s_axis_data_tlast != at_last);
         end
         if (out_handshake) begin
            max_bin <= '0;
            max_mag <= '0;
         end
      end
   end
endmodule
